priority_encoder_8_3: RTL and testbench

- Registered 8-to-3 priority encoder with request capture and acknowledge handshake. Functional inverse of the lab's 3-to-8 decoder.
- Rising edges on eight request lines are latched as pending.
- The highest-priority pending line is presented as a 3-bit code with a valid flag and held until the consumer acknowledges it.
- Used as the encode end of decoder/encoder loopback benches and as a simple interrupt-style arbiter in later labs.

---
 rtl/priority_encoder_8_3_pkg.sv | 40 ++++
 rtl/priority_encoder_8_3_edge_capture.sv | 54 +++++
 rtl/priority_encoder_8_3.sv | 105 ++++++++++
 tb/tb_priority_encoder_8_3.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/priority_encoder_8_3_pkg.sv
// ============================================================================
//  Module      : priority_encoder_8_3_pkg
//  Description : Shared widths, FSM encoding and index/one-hot helpers for the
//                8-to-3 priority encoder and the companion 3-to-8 decoder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package priority_encoder_8_3_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Highest set bit wins; an all-zero vector maps to index 0.
    function automatic logic [CODE_W-1:0] prio_idx(input logic [N_REQ-1:0] vec);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

`default_nettype wire

// File: rtl/priority_encoder_8_3_edge_capture.sv
// ============================================================================
//  Module      : priority_encoder_8_3_edge_capture
//  Description : Rising-edge detector per request line with a pending register
//                and a registered overflow pulse.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module priority_encoder_8_3_edge_capture #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic [N-1:0] req,
    input  logic [N-1:0] clr,
    output logic [N-1:0] pending,
    output logic         overflow
);

    logic [N-1:0] req_q;
    logic [N-1:0] pending_q;
    logic [N-1:0] pending_d;
    logic         overflow_q;
    logic         overflow_d;
    logic [N-1:0] rise;
    logic [N-1:0] kept;

    assign rise = req & ~req_q;
    assign kept = pending_q & ~clr;

    // A rise OR-ed in after the clear lets a same-cycle set beat the clear.
    always_comb begin
        pending_d  = kept | rise;
        overflow_d = |(rise & kept);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            req_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            req_q      <= req;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: rtl/priority_encoder_8_3.sv
// ============================================================================
//  Module      : priority_encoder_8_3
//  Description : Registered 8-to-3 priority encoder with edge-captured requests
//                and a valid/ack handshake holding each grant until consumed.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module priority_encoder_8_3
    import priority_encoder_8_3_pkg::*;
#(
    parameter int N = N_REQ,
    parameter int W = CODE_W
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         enb_,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [W-1:0] code,
    output logic         valid,
    output logic [N-1:0] pending,
    output logic         any,
    output logic         overflow
);

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_GRANT = GRANT;

    generate
        if ((N != N_REQ) || (W != CODE_W) || (W != $clog2(N))) begin : g_param_err
            $error("priority_encoder_8_3: N/W inconsistent with package widths");
        end
    endgenerate

    logic [0:0]   state_q;
    logic [0:0]   state_d;
    logic [W-1:0] code_q;
    logic [W-1:0] code_d;
    logic         valid_q;
    logic         valid_d;
    logic [N-1:0] clr;

    priority_encoder_8_3_edge_capture #(
        .N (N)
    ) u_edge_capture (
        .clk      (clk),
        .rst_     (rst_),
        .req      (req),
        .clr      (clr),
        .pending  (pending),
        .overflow (overflow)
    );

    // Disable is checked before ack so a suppressed grant never clears its bit.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        clr     = '0;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (!enb_ && (|pending)) begin
                    code_d  = prio_idx(pending);
                    valid_d = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (enb_) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (ack) begin
                    clr     = onehot(code_q);
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign code  = code_q;
    assign valid = valid_q;
    assign any   = |pending;

endmodule

`default_nettype wire

// File: tb/tb_priority_encoder_8_3.sv
// ============================================================================
//  Module      : tb_priority_encoder_8_3
//  Description : Table-driven self-checking bench for priority_encoder_8_3.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_priority_encoder_8_3;

    logic       clk;
    logic       rst_;
    logic       enb_;
    logic [7:0] req;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic       any;
    logic       overflow;

    priority_encoder_8_3 dut (
        .clk      (clk),
        .rst_     (rst_),
        .enb_     (enb_),
        .req      (req),
        .ack      (ack),
        .code     (code),
        .valid    (valid),
        .pending  (pending),
        .any      (any),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       ack;
        logic       enb_n;
        logic [2:0] code;
        logic       valid;
        logic [7:0] pend;
        logic       ovf;
    } vec_t;

    typedef struct packed {
        logic [2:0] code;
        logic       valid;
        logic [7:0] pend;
        logic       any;
        logic       ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic add(input logic [7:0] r, input logic a, input logic e,
                       input logic [2:0] c, input logic v, input logic [7:0] p,
                       input logic o);
        vec_t x;
        x.req = r; x.ack = a; x.enb_n = e;
        x.code = c; x.valid = v; x.pend = p; x.ovf = o;
        vecs.push_back(x);
    endtask

    task automatic expect_out(input logic [2:0] c, input logic v,
                              input logic [7:0] p, input logic o);
        exp_t e;
        e.code = c; e.valid = v; e.pend = p; e.any = |p; e.ovf = o;
        sb.push_back(e);
    endtask

    task automatic check_out(input string name);
        exp_t e;
        exp_t act;
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, nothing expected", name);
        end else begin
            e   = sb.pop_front();
            act = {code, valid, pending, any, overflow};
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got code=%0d valid=%b pending=%h any=%b ovf=%b, expected code=%0d valid=%b pending=%h any=%b ovf=%b",
                         name, act.code, act.valid, act.pend, act.any, act.ovf,
                         e.code, e.valid, e.pend, e.any, e.ovf);
            end
        end
    endtask

    initial begin
        // {req, ack, enb_} applied before an edge -> {code, valid, pending, overflow} after it
        // single request, held grant, ack
        add(8'h04,0,0, 3'd0,0,8'h04,0);
        add(8'h04,0,0, 3'd2,1,8'h04,0);
        for (int i = 0; i < 5; i++) add(8'h04,0,0, 3'd2,1,8'h04,0);
        add(8'h04,1,0, 3'd2,0,8'h00,0);
        add(8'h00,0,0, 3'd2,0,8'h00,0);
        // priority 6 over 1, late bit 7 does not pre-empt
        add(8'h42,0,0, 3'd2,0,8'h42,0);
        add(8'h42,0,0, 3'd6,1,8'h42,0);
        add(8'hC2,0,0, 3'd6,1,8'hC2,0);
        add(8'hC2,1,0, 3'd6,0,8'h82,0);
        add(8'hC2,0,0, 3'd7,1,8'h82,0);
        add(8'hC2,1,0, 3'd7,0,8'h02,0);
        add(8'hC2,0,0, 3'd1,1,8'h02,0);
        add(8'hC2,1,0, 3'd1,0,8'h00,0);
        add(8'h00,0,0, 3'd1,0,8'h00,0);
        // disable suppresses grants and beats ack
        add(8'h08,0,1, 3'd1,0,8'h08,0);
        add(8'h08,0,1, 3'd1,0,8'h08,0);
        add(8'h08,0,0, 3'd3,1,8'h08,0);
        add(8'h08,1,1, 3'd3,0,8'h08,0);
        add(8'h08,0,0, 3'd3,1,8'h08,0);
        add(8'h08,1,0, 3'd3,0,8'h00,0);
        add(8'h00,0,0, 3'd3,0,8'h00,0);
        // rise coinciding with ack keeps the bit pending
        add(8'h20,0,0, 3'd3,0,8'h20,0);
        add(8'h20,0,0, 3'd5,1,8'h20,0);
        add(8'h00,0,0, 3'd5,1,8'h20,0);
        add(8'h20,1,0, 3'd5,0,8'h20,0);
        add(8'h20,0,0, 3'd5,1,8'h20,0);
        add(8'h20,1,0, 3'd5,0,8'h00,0);
        // overflow on a second edge of an already-pending bit
        add(8'h24,0,0, 3'd5,0,8'h04,0);
        add(8'h20,0,0, 3'd2,1,8'h04,0);
        add(8'h24,0,0, 3'd2,1,8'h04,1);
        add(8'h24,0,0, 3'd2,1,8'h04,0);
        add(8'h24,1,0, 3'd2,0,8'h00,0);
        // ack while idle is ignored; lowest index is code 0
        add(8'h25,0,1, 3'd2,0,8'h01,0);
        add(8'h25,1,1, 3'd2,0,8'h01,0);
        add(8'h25,0,0, 3'd0,1,8'h01,0);

        rst_ = 1'b0;
        enb_ = 1'b0;
        ack  = 1'b0;
        req  = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        expect_out(3'd0, 1'b0, 8'h00, 1'b0);
        check_out("reset_hold");

        @(negedge clk);
        rst_ = 1'b1;
        #1;
        expect_out(3'd0, 1'b0, 8'h00, 1'b0);
        check_out("reset_release");
        req = 8'h00;
        @(posedge clk);
        #1;
        expect_out(3'd0, 1'b0, 8'h00, 1'b0);
        check_out("first_edge_idle");

        for (int i = 0; i < vecs.size(); i++) begin
            req  = vecs[i].req;
            ack  = vecs[i].ack;
            enb_ = vecs[i].enb_n;
            expect_out(vecs[i].code, vecs[i].valid, vecs[i].pend, vecs[i].ovf);
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i));
        end

        // asynchronous reset while the last vector's grant is still valid
        ack = 1'b0;
        #2;
        rst_ = 1'b0;
        #1;
        expect_out(3'd0, 1'b0, 8'h00, 1'b0);
        check_out("async_reset_mid_grant");
        @(negedge clk);
        rst_ = 1'b1;
        req  = 8'h00;
        @(posedge clk);
        #1;
        expect_out(3'd0, 1'b0, 8'h00, 1'b0);
        check_out("after_async_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
